// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end.
package fetch_unit_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned INST_BYTES = 4;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_REQ   = 2'd0,
      FETCH_HOLD  = 2'd1,
      FETCH_DRAIN = 2'd2
   } fetch_state_e;

   // Clear the byte offset of a fetch address.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs a req/ack handshake to imem,
// skid-buffers one instruction while decode stalls, and drains on redirect.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_data_i,
   output logic            valid_o,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] buf_inst_q, buf_inst_d;
   logic [XLEN-1:0] pend_target_q, pend_target_d;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] target_al;

   assign pc_inc      = pc_q + XLEN'(INST_BYTES);
   assign target_al   = word_align(target_i);
   assign imem_addr_o = pc_q;

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= FETCH_REQ;
         pc_q          <= RESET_PC;
         buf_inst_q    <= NOP_INST;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         buf_inst_q    <= buf_inst_d;
         pend_target_q <= pend_target_d;
      end
   end

   // Next-state and combinational outputs consumed directly by IF/ID.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      buf_inst_d    = buf_inst_q;
      pend_target_d = pend_target_q;
      imem_req_o    = 1'b0;
      valid_o       = 1'b0;
      inst_o        = NOP_INST;
      pc_o          = '0;

      if (!rst_i) begin
         unique case (state_q)
            FETCH_REQ: begin
               imem_req_o = 1'b1;
               if (imem_ack_i) begin
                  if (redirect_i) begin
                     pc_d = target_al;
                  end else begin
                     valid_o = 1'b1;
                     inst_o  = imem_data_i;
                     pc_o    = pc_inc;
                     if (stall_i) begin
                        buf_inst_d = imem_data_i;
                        state_d    = FETCH_HOLD;
                     end else begin
                        pc_d = pc_inc;
                     end
                  end
               end else if (redirect_i) begin
                  pend_target_d = target_al;
                  state_d       = FETCH_DRAIN;
               end
            end

            FETCH_HOLD: begin
               if (redirect_i) begin
                  pc_d    = target_al;
                  state_d = FETCH_REQ;
               end else begin
                  valid_o = 1'b1;
                  inst_o  = buf_inst_q;
                  pc_o    = pc_inc;
                  if (!stall_i) begin
                     pc_d    = pc_inc;
                     state_d = FETCH_REQ;
                  end
               end
            end

            FETCH_DRAIN: begin
               // Request stays up at the old pc until memory answers.
               imem_req_o = 1'b1;
               if (redirect_i) begin
                  pend_target_d = target_al;
               end
               if (imem_ack_i) begin
                  pc_d    = redirect_i ? target_al : pend_target_q;
                  state_d = FETCH_REQ;
               end
            end

            default: begin
               state_d = FETCH_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clk;
   logic        rst, stall, redirect;
   logic [31:0] target;
   logic        imem_req, imem_ack, valid;
   logic [31:0] imem_addr, imem_data, inst, pc_out;

   logic        rst_w;
   logic        req_w, valid_w;
   logic [31:0] addr_w, data_w, inst_w, pc_w;

   int          checks = 0;
   int          failures = 0;

   int          mem_lat;
   int          wait_cnt;
   logic        ack_force;
   logic        ovr_en;
   logic [31:0] ovr_addr, ovr_data;

   fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
      .target_i(target), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_ack_i(imem_ack), .imem_data_i(imem_data), .valid_o(valid),
      .inst_o(inst), .pc_o(pc_out)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk_i(clk), .rst_i(rst_w), .stall_i(1'b0), .redirect_i(1'b0),
      .target_i(32'h0), .imem_req_o(req_w), .imem_addr_o(addr_w),
      .imem_ack_i(1'b1), .imem_data_i(data_w), .valid_o(valid_w),
      .inst_o(inst_w), .pc_o(pc_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ack after mem_lat cycles of an outstanding request.
   always_comb begin
      imem_ack  = ack_force | (imem_req && (wait_cnt == mem_lat - 1));
      imem_data = (ovr_en && imem_addr == ovr_addr) ? ovr_data : ~imem_addr;
   end
   assign data_w = ~addr_w;

   always @(posedge clk) begin
      if (rst || !imem_req || imem_ack) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0; ack_force = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      mem_lat = 1; ack_force = 1'b1; rst = 1'b1;
      step();
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
      checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
      checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
      ack_force = 1'b0;
   endtask

   task automatic test_zero_wait();
      logic [31:0] a;
      mem_lat = 1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         a = 32'h100 + 32'(4 * i);
         #1;
         checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin failures++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem_addr, a); end
         checks++; if (valid !== 1'b1 || pc_out !== a + 32'h4) begin failures++; $display("FAIL zw_pc[%0d] got=%h valid=%0b exp=%h", i, pc_out, valid, a + 32'h4); end
         checks++; if (inst !== ~a) begin failures++; $display("FAIL zw_inst[%0d] got=%h exp=%h", i, inst, ~a); end
         step();
      end
   endtask

   task automatic test_latency();
      mem_lat = 3;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL lat_addr[%0d] got=%h exp=00000100", i, imem_addr); end
         checks++; if (valid !== 1'b0 || inst !== 32'h0) begin failures++; $display("FAIL lat_bubble[%0d] valid=%0b inst=%h exp valid=0 inst=0", i, valid, inst); end
         step();
      end
      #1;
      checks++; if (valid !== 1'b1 || inst !== ~32'h100 || pc_out !== 32'h104) begin failures++; $display("FAIL lat_data valid=%0b inst=%h pc=%h exp 1/%h/00000104", valid, inst, pc_out, ~32'h100); end
      step();
      #1;
      checks++; if (imem_addr !== 32'h104 || valid !== 1'b0) begin failures++; $display("FAIL lat_next addr=%h valid=%0b exp 00000104/0", imem_addr, valid); end
   endtask

   task automatic test_stall_hold();
      mem_lat = 1; ovr_en = 1'b1; ovr_addr = 32'h108; ovr_data = 32'hDEAD_BEEF;
      do_reset();
      step();
      step();
      stall = 1'b1;
      #1;
      checks++; if (imem_addr !== 32'h108 || valid !== 1'b1 || inst !== 32'hDEAD_BEEF || pc_out !== 32'h10C) begin failures++; $display("FAIL hold_capture addr=%h valid=%0b inst=%h pc=%h", imem_addr, valid, inst, pc_out); end
      step();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req[%0d] got=%0b exp=0", i, imem_req); end
         checks++; if (valid !== 1'b1 || inst !== 32'hDEAD_BEEF || pc_out !== 32'h10C) begin failures++; $display("FAIL hold_out[%0d] valid=%0b inst=%h pc=%h exp 1/deadbeef/0000010c", i, valid, inst, pc_out); end
         step();
      end
      stall = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || valid !== 1'b1 || inst !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hold_release req=%0b valid=%0b inst=%h", imem_req, valid, inst); end
      step();
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin failures++; $display("FAIL hold_next req=%0b addr=%h exp 1/0000010c", imem_req, imem_addr); end
      ovr_en = 1'b0;
   endtask

   task automatic test_redirect_drain();
      mem_lat = 3;
      do_reset();
      redirect = 1'b1; target = 32'h200;
      #1;
      checks++; if (imem_addr !== 32'h100 || valid !== 1'b0) begin failures++; $display("FAIL drain_c0 addr=%h valid=%0b exp 00000100/0", imem_addr, valid); end
      step();
      target = 32'h300;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid !== 1'b0) begin failures++; $display("FAIL drain_c1 req=%0b addr=%h valid=%0b", imem_req, imem_addr, valid); end
      step();
      redirect = 1'b0; target = 32'h0;
      #1;
      checks++; if (imem_ack !== 1'b1 || imem_addr !== 32'h100 || valid !== 1'b0 || inst !== 32'h0) begin failures++; $display("FAIL drain_ack ack=%0b addr=%h valid=%0b inst=%h", imem_ack, imem_addr, valid, inst); end
      step();
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL drain_next addr=%h exp=00000300", imem_addr); end
   endtask

   task automatic test_redirect_stall_ack();
      mem_lat = 1;
      do_reset();
      redirect = 1'b1; stall = 1'b1; target = 32'h203;
      #1;
      checks++; if (valid !== 1'b0 || inst !== 32'h0 || pc_out !== 32'h0) begin failures++; $display("FAIL rsa_out valid=%0b inst=%h pc=%h exp 0/0/0", valid, inst, pc_out); end
      step();
      redirect = 1'b0; stall = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rsa_next req=%0b addr=%h exp 1/00000200", imem_req, imem_addr); end
   endtask

   task automatic test_reset_mid();
      mem_lat = 3;
      do_reset();
      step();
      rst = 1'b1; ack_force = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0 || valid !== 1'b0) begin failures++; $display("FAIL rmid_in_reset req=%0b valid=%0b exp 0/0", imem_req, valid); end
      step();
      rst = 1'b0; ack_force = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid !== 1'b0) begin failures++; $display("FAIL rmid_restart req=%0b addr=%h valid=%0b exp 1/00000100/0", imem_req, imem_addr, valid); end
   endtask

   task automatic test_wrap();
      rst_w = 1'b1;
      step();
      rst_w = 1'b0;
      #1;
      checks++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", addr_w); end
      checks++; if (valid_w !== 1'b1 || pc_w !== 32'h0 || inst_w !== 32'h3) begin failures++; $display("FAIL wrap_pc valid=%0b pc=%h inst=%h exp 1/0/3", valid_w, pc_w, inst_w); end
      step();
      #1;
      checks++; if (addr_w !== 32'h0 || pc_w !== 32'h4) begin failures++; $display("FAIL wrap_next addr=%h pc=%h exp 0/4", addr_w, pc_w); end
   endtask

   initial begin
      rst = 1'b1; rst_w = 1'b1; stall = 1'b0; redirect = 1'b0; target = 32'h0;
      ack_force = 1'b0; mem_lat = 1; ovr_en = 1'b0; ovr_addr = 32'h0; ovr_data = 32'h0;
      test_reset();
      test_zero_wait();
      test_latency();
      test_stall_hold();
      test_redirect_drain();
      test_redirect_stall_ack();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout sim_time=%0t limit=200000", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that produces the PC+4 / instruction pair consumed by the IF/ID pipeline register. Owns the program counter and a variable-latency req/ack handshake to instruction memory, and skid-buffers one returned instruction while decode is stalled. On a branch redirect it drains any outstanding memory request. Emits a NOP bubble (32'h0) on any cycle where no valid instruction is ready.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  hold request from hazard unit; same meaning as the IF/ID hold: 1 = decode does not accept this cycle
- redirect_i  in  1  branch/jump taken; fetch must restart at target_i
- target_i  in  32  redirect address; bits [1:0] ignored and forced to 00
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  32  fetch address, word aligned
- imem_ack_i  in  1  memory response valid; only meaningful while imem_req_o=1
- imem_data_i  in  32  instruction word, valid with imem_ack_i
- valid_o  out  1  inst_o/pc_o carry a real instruction this cycle
- inst_o  out  32  instruction to IF/ID; 32'h0 when valid_o=0
- pc_o  out  32  fetch address + 4; 32'h0 when valid_o=0

## Operation
- States: REQ (request outstanding), HOLD (one instruction buffered, waiting for stall release), DRAIN (redirect received while a request is outstanding; discard its response).
- Registers: pc (32), buf_inst (32), pend_target (32), state.
- Reset (rst_i=1): pc<=RESET_PC, state<=REQ. While rst_i=1, imem_req_o=0, valid_o=0, inst_o=0, pc_o=0, and any ack is ignored.
- Handshake: once imem_req_o=1, imem_addr_o stays constant until the cycle imem_ack_i=1. Never abandon a request except through reset. Instruction memory shares rst_i.
- REQ: imem_req_o=1, imem_addr_o=pc.
  - ack & redirect: discard data, valid_o=0, pc<=target, stay REQ.
  - ack & !redirect & !stall: valid_o=1, inst_o=imem_data_i, pc_o=pc+4; pc<=pc+4.
  - ack & !redirect & stall: valid_o=1 with the same data; buf_inst<=data; go to HOLD.
  - !ack & redirect: pend_target<=target; go to DRAIN.
  - !ack & !redirect: valid_o=0.
- HOLD: imem_req_o=0, valid_o=1, inst_o=buf_inst, pc_o=pc+4.
  - redirect: valid_o forced 0, pc<=target, go to REQ.
  - !stall: pc<=pc+4, go to REQ.
  - otherwise remain in HOLD.
- DRAIN: imem_req_o=1 at the old pc, valid_o=0.
  - redirect: pend_target<=target (latest wins).
  - ack: discard data; pc<=(redirect ? target : pend_target); go to REQ.
- Priority: rst_i > redirect_i > stall_i.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing
- valid_o, inst_o, pc_o and imem_req_o are combinational from state and inputs. IF/ID samples them at the next edge, so there is no added register stage.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle, with the first request in the first cycle after rst_i falls.
- An N-cycle memory latency produces N-1 bubble cycles per instruction.
- Stall release from HOLD: the buffered instruction is taken at the release edge. The next request is issued in the following cycle, giving one bubble.
- Redirect in REQ with ack: the new target is requested in the next cycle.
- Redirect in REQ without ack: the target is requested in the cycle after the drained ack.

## Structure
- Shared pipeline package holds:
  - state enum: FETCH_REQ, FETCH_HOLD, FETCH_DRAIN
  - NOP_INST = 32'h0
  - INST_BYTES = 4
- Single module; no sub-module is needed. The skid buffer is one register.

## Test plan
- RESET_PC=32'h100, ack tied to 1 → addresses 0x100, 0x104, 0x108 on consecutive cycles; pc_o 0x104, 0x108, 0x10C; valid_o=1 every cycle.
- Ack latency 3 → addr held at 0x100 for 3 cycles, valid_o=0 and inst_o=0 for the first 2, valid on the 3rd; next request is 0x104.
- Data 0xDEADBEEF returns for 0x108 while stall_i=1 for 3 cycles → HOLD with imem_req_o=0, inst_o=0xDEADBEEF and pc_o=0x10C held; the request for 0x10C appears the cycle after stall_i falls.
- Latency 3; redirect_i pulse to 0x200 in cycle 1 and to 0x300 in cycle 2 → addr stays 0x100 until ack, data discarded with valid_o=0, next request 0x300.
- redirect_i (target 0x203), stall_i and ack in the same REQ cycle → valid_o=0, no HOLD, next request 0x200.
- RESET_PC=32'hFFFF_FFFC, ack tied to 1 → pc_o=0, next address 0x0. Assert rst_i while a request is outstanding → imem_req_o=0 during reset, restart at RESET_PC.
